// File: rtl/mvm_uart_rx.sv
// ---------------------------------------------------------------------------
// mvm_uart_rx
//
// UART receiver feeding the MVM input deserializer. The serial line is
// brought into the clock domain through two flops. Each bit is sampled in
// the middle of its bit period. A received word is presented on a
// one-entry valid/ready output register.
//
// Parameters
//   CLOCKS_PER_PULSE : clocks per UART bit (>= 2), same as the transmitter
//   BITS_PER_WORD    : data bits per frame, LSB first
//
// Ports
//   clk       : single clock, rising edge
//   rst       : synchronous active-high reset
//   rx        : asynchronous serial input, idles high
//   m_data    : received word, stable while m_valid is high
//   m_valid   : m_data holds an unconsumed word
//   m_ready   : consumer accepts the word when m_valid & m_ready
//   frame_err : one-cycle pulse on a low stop bit (or a parity mismatch)
//   overrun   : one-cycle pulse when a finished word is dropped because the
//               output register is still full
//   busy      : receiver FSM is not idle
//
// Build option
//   UART_RX_PARITY_EN : when defined, each frame carries one even-parity bit
//                       after the data bits. A mismatch drops the word and
//                       pulses frame_err. When undefined, the frame is
//                       start + data + stop.
// ---------------------------------------------------------------------------
module mvm_uart_rx #(
  parameter int CLOCKS_PER_PULSE = 4,
  parameter int BITS_PER_WORD    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx,
  output logic [BITS_PER_WORD-1:0] m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     frame_err,
  output logic                     overrun,
  output logic                     busy
);

  localparam int CNT_W = $clog2(CLOCKS_PER_PULSE);
  localparam int IDX_W = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;

  // The first wait is half a bit, so later samples land mid-bit.
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLOCKS_PER_PULSE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLOCKS_PER_PULSE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BITS_PER_WORD - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } state_t;
`endif

  state_t                   state_reg, state_next;
  logic [CNT_W-1:0]         cnt_reg, cnt_next;
  logic [IDX_W-1:0]         idx_reg, idx_next;
  logic [BITS_PER_WORD-1:0] shift_reg;
  logic                     rx_meta_reg, rxs;
  logic                     tick;
  logic                     bit_load;
  logic                     word_done;
  logic                     frame_err_next;
`ifdef UART_RX_PARITY_EN
  logic                     par_err_reg, par_err_next;
`endif

  // -------------------------------------------------------------------------
  // Two-flop synchronizer. Both flops reset to the idle level, so a line
  // held low through reset is seen two clocks after release.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_reg <= 1'b1;
      rxs         <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rxs         <= rx_meta_reg;
    end
  end

  assign tick = (cnt_reg == '0);

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par_err_reg <= 1'b0;
    end else begin
      par_err_reg <= par_err_next;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // FSM next-state and control strobes
  // -------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    idx_next       = idx_reg;
    bit_load       = 1'b0;
    word_done      = 1'b0;
    frame_err_next = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_next   = par_err_reg;
`endif

    case (state_reg)
      ST_IDLE: begin
        if (!rxs) begin
          cnt_next   = CNT_HALF;
          state_next = ST_START;
        end
      end

      ST_START: begin
        if (tick) begin
          if (rxs) begin
            // The line went back high before mid-start: treat it as noise.
            state_next = ST_IDLE;
          end else begin
            idx_next   = '0;
            cnt_next   = CNT_FULL;
            state_next = ST_DATA;
          end
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      ST_DATA: begin
        if (tick) begin
          bit_load = 1'b1;
          cnt_next = CNT_FULL;
          if (idx_reg == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_next = ST_PARITY;
`else
            state_next = ST_STOP;
`endif
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          // Even parity: the data bits and the parity bit XOR to zero.
          par_err_next = rxs ^ (^shift_reg);
          cnt_next     = CNT_FULL;
          state_next   = ST_STOP;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
`endif

      ST_STOP: begin
        if (tick) begin
          if (!rxs) begin
            // The line may be in a break. Wait for it to return high so
            // that one long low level gives only one error.
            frame_err_next = 1'b1;
            state_next     = ST_WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
          end else if (par_err_reg) begin
            frame_err_next = 1'b1;
            state_next     = ST_IDLE;
`endif
          end else begin
            // Go straight to IDLE so a start bit that follows at once is
            // still caught.
            word_done  = 1'b1;
            state_next = ST_IDLE;
          end
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      ST_WAIT_HIGH: begin
        if (rxs) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Shift register. Each bit has its own write enable, selected by the
  // current bit index.
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < BITS_PER_WORD; gi++) begin : g_shift
      always_ff @(posedge clk) begin
        if (rst) begin
          shift_reg[gi] <= 1'b0;
        end else if (bit_load && (idx_reg == IDX_W'(gi))) begin
          shift_reg[gi] <= rxs;
        end
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Output register with valid/ready handshake and status pulses.
  // An accept on the same cycle as a finished word frees the slot, so the
  // new word loads and there is no overrun.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      m_data    <= '0;
      m_valid   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= frame_err_next;
      overrun   <= 1'b0;
      if (word_done && (!m_valid || m_ready)) begin
        m_data  <= shift_reg;
        m_valid <= 1'b1;
      end else begin
        if (word_done) begin
          overrun <= 1'b1;
        end
        if (m_valid && m_ready) begin
          m_valid <= 1'b0;
        end
      end
    end
  end

  assign busy = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_mvm_uart_rx.sv
module tb_mvm_uart_rx;

  localparam int CPP = 4;
  localparam int BPW = 8;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  // Clocks per frame: start + data + optional parity + stop.
  localparam int FRAME_CLKS = (BPW + 2 + P) * CPP;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           rx = 1'b1;
  logic           m_ready = 1'b0;
  logic [BPW-1:0] m_data;
  logic           m_valid;
  logic           frame_err;
  logic           overrun;
  logic           busy;

  int n_checks = 0;
  int n_pass   = 0;

  mvm_uart_rx #(
    .CLOCKS_PER_PULSE(CPP),
    .BITS_PER_WORD   (BPW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then step 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one frame. Each bit lasts CPP clocks and starts 1 unit after an edge.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
    rx = 1'b0;
    tick(CPP);
    for (int i = 0; i < BPW; i++) begin
      rx = d[i];
      tick(CPP);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ par_flip;
    tick(CPP);
`else
    if (par_flip) rx = 1'b1;
`endif
    rx = stop_bit;
    tick(CPP);
    rx = 1'b1;
  endtask

  task automatic test_reset();
    int vcnt;
    int fcnt;
    rst = 1'b1;
    rx  = 1'b1;
    tick(3);
    n_checks++; if (m_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", m_valid); else n_pass++;
    n_checks++; if (m_data !== 8'h00) $display("FAIL reset_data: got %h expected 00", m_data); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    rst = 1'b0;
    tick(2);
    // Start a frame, then abort it with reset while the line is still low.
    rx = 1'b0;
    tick(15);
    n_checks++; if (busy !== 1'b1) $display("FAIL midframe_busy: got %b expected 1", busy); else n_pass++;
    rst = 1'b1;
    tick(3);
    n_checks++; if (busy !== 1'b0) $display("FAIL midreset_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if ({m_valid, frame_err, overrun} !== 3'b000)
      $display("FAIL midreset_flags: got %b expected 000", {m_valid, frame_err, overrun}); else n_pass++;
    rst = 1'b0;
    rx  = 1'b1;
    vcnt = 0;
    fcnt = 0;
    for (int i = 0; i < FRAME_CLKS + 20; i++) begin
      tick(1);
      if (m_valid) vcnt++;
      if (frame_err || overrun) fcnt++;
    end
    n_checks++; if (vcnt !== 0) $display("FAIL aborted_no_word: got %0d valid cycles expected 0", vcnt); else n_pass++;
    n_checks++; if (fcnt !== 0) $display("FAIL aborted_no_flags: got %0d flag cycles expected 0", fcnt); else n_pass++;
    $display("test_reset: aborted frame discarded, valid cycles %0d", vcnt);
  endtask

  task automatic test_single_byte();
    int lat;
    int vcnt;
    int fcnt;
    logic [7:0] got;
    lat  = 0;
    vcnt = 0;
    fcnt = 0;
    got  = 8'h00;
    m_ready = 1'b1;
    fork
      send_frame(8'hA5, 1'b1, 1'b0);
      begin
        for (int i = 1; i <= FRAME_CLKS + 20; i++) begin
          tick(1);
          if (m_valid) begin
            vcnt++;
            if (lat == 0) begin
              lat = i;
              got = m_data;
            end
          end
          if (frame_err || overrun) fcnt++;
        end
      end
    join
    m_ready = 1'b0;
    $display("test_single_byte: received 0x%02h after %0d clocks", got, lat);
    n_checks++; if (got !== 8'hA5) $display("FAIL single_data: got %h expected a5", got); else n_pass++;
    n_checks++; if (lat !== FRAME_CLKS + 1) $display("FAIL single_latency: got %0d expected %0d", lat, FRAME_CLKS + 1); else n_pass++;
    n_checks++; if (vcnt !== 1) $display("FAIL single_valid_width: got %0d expected 1", vcnt); else n_pass++;
    n_checks++; if (fcnt !== 0) $display("FAIL single_flags: got %0d expected 0", fcnt); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int ov_cnt;
    int ov_at;
    int bad_data;
    ov_cnt   = 0;
    ov_at    = 0;
    bad_data = 0;
    m_ready  = 1'b0;
    fork
      begin
        send_frame(8'h3C, 1'b1, 1'b0);
        send_frame(8'hC3, 1'b1, 1'b0);
      end
      begin
        for (int i = 1; i <= 2 * FRAME_CLKS + 20; i++) begin
          tick(1);
          if (overrun) begin
            ov_cnt++;
            ov_at = i;
          end
          if (m_valid && (m_data !== 8'h3C)) bad_data++;
        end
      end
    join
    $display("test_back_to_back: held 0x%02h, overrun pulses %0d at clock %0d", m_data, ov_cnt, ov_at);
    n_checks++; if (m_valid !== 1'b1) $display("FAIL b2b_valid: got %b expected 1", m_valid); else n_pass++;
    n_checks++; if (m_data !== 8'h3C) $display("FAIL b2b_data: got %h expected 3c", m_data); else n_pass++;
    n_checks++; if (bad_data !== 0) $display("FAIL b2b_data_stable: got %0d changed cycles expected 0", bad_data); else n_pass++;
    n_checks++; if (ov_cnt !== 1) $display("FAIL b2b_overrun_count: got %0d expected 1", ov_cnt); else n_pass++;
    n_checks++; if (ov_at !== 2 * FRAME_CLKS + 1) $display("FAIL b2b_overrun_time: got %0d expected %0d", ov_at, 2 * FRAME_CLKS + 1); else n_pass++;
    m_ready = 1'b1;
    tick(1);
    m_ready = 1'b0;
    n_checks++; if (m_valid !== 1'b0) $display("FAIL b2b_consume: got %b expected 0", m_valid); else n_pass++;
  endtask

  task automatic test_simultaneous_accept();
    int ov_cnt;
    ov_cnt  = 0;
    m_ready = 1'b0;
    send_frame(8'h3C, 1'b1, 1'b0);
    fork
      send_frame(8'hC3, 1'b1, 1'b0);
      begin
        tick(FRAME_CLKS);
        n_checks++; if (m_data !== 8'h3C) $display("FAIL simul_pre_data: got %h expected 3c", m_data); else n_pass++;
        // The next edge completes the second word; accept the first on it.
        m_ready = 1'b1;
        tick(1);
        m_ready = 1'b0;
        if (overrun) ov_cnt++;
        n_checks++; if (m_valid !== 1'b1) $display("FAIL simul_valid: got %b expected 1", m_valid); else n_pass++;
        n_checks++; if (m_data !== 8'hC3) $display("FAIL simul_data: got %h expected c3", m_data); else n_pass++;
        for (int i = 0; i < 5; i++) begin
          tick(1);
          if (overrun) ov_cnt++;
        end
      end
    join
    $display("test_simultaneous_accept: received 0x%02h, overrun pulses %0d", m_data, ov_cnt);
    n_checks++; if (ov_cnt !== 0) $display("FAIL simul_overrun: got %0d expected 0", ov_cnt); else n_pass++;
    m_ready = 1'b1;
    tick(1);
    m_ready = 1'b0;
  endtask

  task automatic test_frame_error_break();
    int fe_cnt;
    int fe_at;
    int vcnt;
    fe_cnt  = 0;
    fe_at   = 0;
    vcnt    = 0;
    m_ready = 1'b0;
    fork
      begin
        send_frame(8'h55, 1'b0, 1'b0);
        rx = 1'b0;
        tick(40);
        rx = 1'b1;
      end
      begin
        for (int i = 1; i <= FRAME_CLKS + 60; i++) begin
          tick(1);
          if (frame_err) begin
            fe_cnt++;
            if (fe_at == 0) fe_at = i;
          end
          if (m_valid) vcnt++;
        end
      end
    join
    $display("test_frame_error_break: frame_err pulses %0d at clock %0d, valid cycles %0d", fe_cnt, fe_at, vcnt);
    n_checks++; if (fe_cnt !== 1) $display("FAIL break_fe_count: got %0d expected 1", fe_cnt); else n_pass++;
    n_checks++; if (fe_at !== FRAME_CLKS + 1) $display("FAIL break_fe_time: got %0d expected %0d", fe_at, FRAME_CLKS + 1); else n_pass++;
    n_checks++; if (vcnt !== 0) $display("FAIL break_no_valid: got %0d expected 0", vcnt); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL break_idle: got %b expected 0", busy); else n_pass++;
    send_frame(8'h01, 1'b1, 1'b0);
    tick(2);
    $display("test_frame_error_break: received 0x%02h after break", m_data);
    n_checks++; if (m_valid !== 1'b1) $display("FAIL after_break_valid: got %b expected 1", m_valid); else n_pass++;
    n_checks++; if (m_data !== 8'h01) $display("FAIL after_break_data: got %h expected 01", m_data); else n_pass++;
    m_ready = 1'b1;
    tick(1);
    m_ready = 1'b0;
  endtask

  task automatic test_glitch();
    int busy_seen;
    int fcnt;
    int vcnt;
    busy_seen = 0;
    fcnt      = 0;
    vcnt      = 0;
    rx = 1'b0;
    tick(1);
    rx = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (busy) busy_seen = 1;
      if (frame_err || overrun) fcnt++;
      if (m_valid) vcnt++;
    end
    $display("test_glitch: busy seen %0d, flag cycles %0d, valid cycles %0d", busy_seen, fcnt, vcnt);
    n_checks++; if (busy_seen !== 1) $display("FAIL glitch_busy_seen: got %0d expected 1", busy_seen); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL glitch_idle: got %b expected 0", busy); else n_pass++;
    n_checks++; if (fcnt !== 0) $display("FAIL glitch_flags: got %0d expected 0", fcnt); else n_pass++;
    n_checks++; if (vcnt !== 0) $display("FAIL glitch_valid: got %0d expected 0", vcnt); else n_pass++;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int fe_cnt;
    int vcnt;
    m_ready = 1'b0;
    send_frame(8'h07, 1'b1, 1'b0);
    tick(2);
    $display("test_parity: good parity received 0x%02h valid %b", m_data, m_valid);
    n_checks++; if (m_valid !== 1'b1) $display("FAIL parity_good_valid: got %b expected 1", m_valid); else n_pass++;
    n_checks++; if (m_data !== 8'h07) $display("FAIL parity_good_data: got %h expected 07", m_data); else n_pass++;
    m_ready = 1'b1;
    tick(1);
    m_ready = 1'b0;
    fe_cnt = 0;
    vcnt   = 0;
    fork
      send_frame(8'h07, 1'b1, 1'b1);
      begin
        for (int i = 0; i < FRAME_CLKS + 10; i++) begin
          tick(1);
          if (frame_err) fe_cnt++;
          if (m_valid) vcnt++;
        end
      end
    join
    $display("test_parity: bad parity frame_err pulses %0d valid cycles %0d", fe_cnt, vcnt);
    n_checks++; if (fe_cnt !== 1) $display("FAIL parity_bad_fe: got %0d expected 1", fe_cnt); else n_pass++;
    n_checks++; if (vcnt !== 0) $display("FAIL parity_bad_valid: got %0d expected 0", vcnt); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_simultaneous_accept();
    test_frame_error_break();
    test_glitch();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mvm_uart_rx.md
# mvm_uart_rx

UART receiver that turns the serial `rx` line into bytes for the matrix-vector-multiply UART system. It sits directly upstream of the MVM input deserializer and shares the transmitter's bit timing (`CLOCKS_PER_PULSE`) and word width (`BITS_PER_WORD`). The input is a 2-flop synchronized line with mid-bit sampling. The output is a one-entry valid/ready byte stream with framing-error and overrun flags.

## Interface
- `CLOCKS_PER_PULSE`, default 4: clocks per UART bit; must be >= 2.
- `BITS_PER_WORD`, default 8: data bits per frame, sent LSB first.
- `clk` input 1: the single clock; all logic is on its rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `rx` input 1: asynchronous serial line; idles high.
- `m_data` output BITS_PER_WORD: received word, held stable while `m_valid` is high.
- `m_valid` output 1: `m_data` holds an unconsumed word.
- `m_ready` input 1: the consumer accepts the word when `m_valid & m_ready`.
- `frame_err` output 1: one-cycle pulse when a stop bit samples low (or parity fails).
- `overrun` output 1: one-cycle pulse when a completed word is dropped because the output register is still full.
- `busy` output 1: high in any state other than IDLE.

## Operation
- Synchronizer: two flops on `rx` reset to 1; `rxs` is the second flop. All sampling uses `rxs`.
- Bit counter: `cnt` (clog2(CLOCKS_PER_PULSE) bits) and bit index `idx`.
- States:
  - IDLE: when `rxs`==0, load `cnt`=CLOCKS_PER_PULSE/2−1 and go to START.
  - START: when `cnt` reaches 0, sample. If `rxs`==1 it is a glitch: return to IDLE with no flags. Otherwise set `idx`=0, reload `cnt`=CLOCKS_PER_PULSE−1 and go to DATA.
  - DATA: at each `cnt`==0, shift `rxs` into shift register bit `idx` (LSB first) and reload `cnt`. After bit BITS_PER_WORD−1 go to PARITY if enabled, otherwise STOP.
  - PARITY (`UART_RX_PARITY_EN` only): sample one bit period and record the mismatch; go to STOP.
  - STOP: at `cnt`==0, sample.
    - `rxs`==1 and no parity error: the word completes; go to IDLE in the same cycle, so back-to-back frames are supported.
    - `rxs`==0: pulse `frame_err`, drop the word and go to WAIT_HIGH.
    - Parity error with `rxs`==1: pulse `frame_err`, drop the word and go to IDLE.
  - WAIT_HIGH: stay until `rxs`==1, then go to IDLE. This makes a break condition produce exactly one `frame_err`.
- Output register, evaluated on the word-complete cycle:
  - If `m_valid`==0, or `m_ready`==1 in the same cycle: load `m_data` and set `m_valid`=1 on the next edge. A simultaneous accept counts as free space, so no overrun.
  - Otherwise: keep the old word and pulse `overrun` for one cycle.
- `m_valid` clears on the edge after `m_valid & m_ready` unless a new word loads on that same edge.
- Reset, including mid-frame: state=IDLE, synchronizer=1, `m_valid`=0, `m_data`=0, `frame_err`=0, `overrun`=0, `busy`=0. A partial frame is discarded. After reset is released, a line that is still low starts a frame in IDLE immediately.

## Timing
- Synchronizer latency: 2 clocks from `rx` to `rxs`.
- Start sample: CLOCKS_PER_PULSE/2 clocks after IDLE first sees `rxs`==0.
- Data bit k sample: (k+1)·CLOCKS_PER_PULSE clocks after the start sample.
- Stop sample: (BITS_PER_WORD+1+P)·CLOCKS_PER_PULSE clocks after the start sample, where P=1 with parity and P=0 without.
- `m_valid` rises 1 clock after the stop sample.
- `frame_err` and `overrun` are registered and assert 1 clock after the stop sample.
- Defaults without parity: `m_valid` rises 2+2+36+1 = 41 clocks after the `rx` falling edge.

## Configuration
- Macro `UART_RX_PARITY_EN`.
  - Defined: the frame carries one even-parity bit after the data bits. A mismatch pulses `frame_err` and the word is dropped.
  - Undefined: no PARITY state, frame = start + BITS_PER_WORD data + stop, and `frame_err` is driven only by the stop bit.
- The matching transmitter must be built with the same setting.

## Test plan
All scenarios use CLOCKS_PER_PULSE=4 and BITS_PER_WORD=8.
- Reset: hold `rst` 3 clocks mid-frame with `rx`=0 → all outputs 0 and `busy`=0; no word is delivered for the aborted frame.
- Single byte: send 0xA5 with `m_ready`=1 → `m_data`=0xA5 and `m_valid` high for exactly 1 cycle, 41 clocks after the start edge.
- Back-to-back with backpressure: send 0x3C then 0xC3 with `m_ready`=0 → `m_data` stays 0x3C and `overrun` pulses once at the second stop sample. Then raise `m_ready` → 0x3C is consumed and `m_valid` falls.
- Simultaneous accept: assert `m_ready` exactly on the second word's complete cycle → no `overrun`; `m_data`=0xC3 on the next cycle.
- Framing error and break: send 0x55 with the stop bit 0, then hold `rx`=0 for 40 clocks → one `frame_err` pulse and no `m_valid`. On `rx` returning high the block reaches IDLE, and a following 0x01 is received correctly.
- Glitch: drop `rx` low for 1 clock only → `busy` rises, then the block returns to IDLE with no flags and no `m_valid`.
- Parity (`UART_RX_PARITY_EN` defined): 0x07 sent with parity bit 1 → received; the same byte with parity bit 0 → `frame_err` and no `m_valid`.
